// File: rtl/ball_motion_scheduler.sv
// Ball motion scheduler: per-frame position/velocity update for NUM_BALLS balls
// through one shared datapath, with host config writes arbitrated against it.
module ball_motion_scheduler #(
   parameter int unsigned NUM_BALLS  = 4,
   parameter int unsigned BALL_SIZE  = 4,
   parameter int unsigned H_LIMIT    = 256,
   parameter int unsigned V_LIMIT    = 240,
   parameter int unsigned INIT_POS   = 128,
   parameter logic [8:0]  INIT_HMOVE = 9'h1FE,
   parameter logic [8:0]  INIT_VMOVE = 9'h002,
   localparam int unsigned IW        = $clog2(NUM_BALLS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic [8:0]    cfg_hpos,
   input  logic [8:0]    cfg_vpos,
   input  logic [8:0]    cfg_hmove,
   input  logic [8:0]    cfg_vmove,
   output logic          cfg_ack,
   input  logic [IW-1:0] rd_idx,
   output logic [8:0]    rd_hpos,
   output logic [8:0]    rd_vpos,
   output logic          busy,
   output logic          frame_done,
   output logic          bounce_h,
   output logic          bounce_v,
   output logic [IW-1:0] bounce_idx,
   output logic          overrun
);

   localparam logic [8:0] H_THRESH = 9'(H_LIMIT - BALL_SIZE);
   localparam logic [8:0] V_THRESH = 9'(V_LIMIT - BALL_SIZE);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   state_t        state, state_next;
   logic [IW-1:0] idx, idx_next;
   logic          pending, pending_next;
   logic          vsync_q;
   logic          edge_det;
   logic          consume;
   logic          upd;

   logic [8:0] hpos  [NUM_BALLS];
   logic [8:0] vpos  [NUM_BALLS];
   logic [8:0] hmove [NUM_BALLS];
   logic [8:0] vmove [NUM_BALLS];

   logic [8:0] nh, nv;
   logic       hit_h, hit_v;

   assign edge_det = vsync & ~vsync_q;
   assign consume  = (state == IDLE) & pending;
   assign upd      = (state == UPDATE);
   assign busy     = (state != IDLE);
   assign cfg_ack  = cfg_we & (state == IDLE) & ~pending;
   assign rd_hpos  = hpos[rd_idx];
   assign rd_vpos  = vpos[rd_idx];

   // Shared per-ball step: add velocity, detect boundary crossing (unsigned compare
   // also catches wrap below zero).
   always_comb begin
      nh    = hpos[idx] + hmove[idx];
      nv    = vpos[idx] + vmove[idx];
      hit_h = (nh >= H_THRESH);
      hit_v = (nv >= V_THRESH);
   end

   // Next-state, ball index and pending-frame logic.
   always_comb begin
      state_next   = state;
      idx_next     = idx;
      pending_next = pending | edge_det;
      case (state)
         IDLE: begin
            if (pending) begin
               state_next   = UPDATE;
               idx_next     = '0;
               pending_next = edge_det;
            end
         end
         UPDATE: begin
            if (idx == IW'(NUM_BALLS - 1)) state_next = DONE;
            else                           idx_next   = idx + IW'(1);
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control registers, status pulses and sticky overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         pending    <= 1'b0;
         vsync_q    <= 1'b0;
         frame_done <= 1'b0;
         bounce_h   <= 1'b0;
         bounce_v   <= 1'b0;
         bounce_idx <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         pending    <= pending_next;
         vsync_q    <= vsync;
         frame_done <= (state_next == DONE);
         bounce_h   <= upd & hit_h;
         bounce_v   <= upd & hit_v;
         if (upd & (hit_h | hit_v)) bounce_idx <= idx;
         if (edge_det & pending & ~consume) overrun <= 1'b1;
      end
   end

   // Ball register file: update engine in UPDATE, host writes only when acked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_BALLS); i++) begin
            hpos[i]  <= 9'(INIT_POS);
            vpos[i]  <= 9'(INIT_POS);
            hmove[i] <= INIT_HMOVE;
            vmove[i] <= INIT_VMOVE;
         end
      end else if (upd) begin
         if (hit_h) hmove[idx] <= 9'd0 - hmove[idx];
         else       hpos[idx]  <= nh;
         if (hit_v) vmove[idx] <= 9'd0 - vmove[idx];
         else       vpos[idx]  <= nv;
      end else if (cfg_ack) begin
         hpos[cfg_idx]  <= cfg_hpos;
         vpos[cfg_idx]  <= cfg_vpos;
         hmove[cfg_idx] <= cfg_hmove;
         vmove[cfg_idx] <= cfg_vmove;
      end
   end

endmodule

// File: tb/tb_ball_motion_scheduler.sv
// Self-checking bench for ball_motion_scheduler: frame-timeline model plus
// directed scenarios with hand-computed expectations.
module tb_ball_motion_scheduler;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          vsync = 1'b0;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [8:0]    cfg_hpos = '0, cfg_vpos = '0, cfg_hmove = '0, cfg_vmove = '0;
   logic          cfg_ack;
   logic [IW-1:0] rd_idx = '0;
   logic [8:0]    rd_hpos, rd_vpos;
   logic          busy, frame_done, bounce_h, bounce_v, overrun;
   logic [IW-1:0] bounce_idx;

   int checks = 0;
   int passes = 0;

   ball_motion_scheduler dut (
      .clk(clk), .reset(reset), .vsync(vsync),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_hpos(cfg_hpos), .cfg_vpos(cfg_vpos),
      .cfg_hmove(cfg_hmove), .cfg_vmove(cfg_vmove), .cfg_ack(cfg_ack),
      .rd_idx(rd_idx), .rd_hpos(rd_hpos), .rd_vpos(rd_vpos),
      .busy(busy), .frame_done(frame_done), .bounce_h(bounce_h), .bounce_v(bounce_v),
      .bounce_idx(bounce_idx), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // m_phase: 0 = idle, 1..N = frame slot handling ball (m_phase-1), N+1 = wrap-up cycle.
   int m_h[N], m_v[N], m_hm[N], m_vm[N];
   int m_phase, m_bidx;
   bit m_pend, m_vq, m_ovr, m_bh, m_bv;
   bit s_edge, s_consume, s_ack, s_b;
   int s_np, s_nm, s_k;

   task automatic axis(input int p, input int m, input int lim,
                       output int np, output int nm, output bit b);
      int s;
      s = (p + m) % 512;
      if (s >= lim - 4) begin np = p; nm = (512 - m) % 512; b = 1; end
      else              begin np = s; nm = m;               b = 0; end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_h[i] = 128; m_v[i] = 128; m_hm[i] = 510; m_vm[i] = 2;
         end
         m_phase = 0; m_bidx = 0;
         m_pend = 0; m_vq = 0; m_ovr = 0; m_bh = 0; m_bv = 0;
      end else begin
         s_ack  = cfg_we && m_phase == 0 && !m_pend;
         s_edge = vsync && !m_vq;
         m_vq   = vsync;
         m_bh = 0; m_bv = 0;
         if (m_phase >= 1 && m_phase <= N) begin
            s_k = m_phase - 1;
            axis(m_h[s_k], m_hm[s_k], 256, s_np, s_nm, s_b);
            m_h[s_k] = s_np; m_hm[s_k] = s_nm; m_bh = s_b;
            axis(m_v[s_k], m_vm[s_k], 240, s_np, s_nm, s_b);
            m_v[s_k] = s_np; m_vm[s_k] = s_nm; m_bv = s_b;
            if (m_bh || m_bv) m_bidx = s_k;
         end
         s_consume = m_phase == 0 && m_pend;
         if (s_edge && m_pend && !s_consume) m_ovr = 1;
         m_pend = s_consume ? s_edge : (m_pend || s_edge);
         if (s_ack) begin
            m_h[cfg_idx]  = int'(cfg_hpos);
            m_v[cfg_idx]  = int'(cfg_vpos);
            m_hm[cfg_idx] = int'(cfg_hmove);
            m_vm[cfg_idx] = int'(cfg_vmove);
         end
         if (m_phase == 0)      m_phase = s_consume ? 1 : 0;
         else if (m_phase <= N) m_phase = m_phase + 1;
         else                   m_phase = 0;
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (!reset) begin
         chk("busy", int'(busy), int'(m_phase != 0));
         chk("frame_done", int'(frame_done), int'(m_phase == N + 1));
         chk("bounce_h", int'(bounce_h), int'(m_bh));
         chk("bounce_v", int'(bounce_v), int'(m_bv));
         if (m_bh || m_bv) chk("bounce_idx", int'(bounce_idx), m_bidx);
         chk("overrun", int'(overrun), int'(m_ovr));
         chk("cfg_ack", int'(cfg_ack), int'(cfg_we && m_phase == 0 && !m_pend));
         chk("rd_hpos", int'(rd_hpos), m_h[rd_idx]);
         chk("rd_vpos", int'(rd_vpos), m_v[rd_idx]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #2;
      rd_idx = rd_idx + IW'(1);
   endtask

   task automatic read_ball(input int i, input int eh, input int ev);
      rd_idx = IW'(i);
      @(negedge clk);
      chk($sformatf("ball%0d_hpos", i), int'(rd_hpos), eh);
      chk($sformatf("ball%0d_vpos", i), int'(rd_vpos), ev);
   endtask

   // Raise vsync and wait for the frame; reports latency, busy length and bounces.
   task automatic frame(output int lat, output int bcnt,
                        output bit bh, output int bh_idx, output bit bv, output int bv_idx);
      bit seen;
      seen = 0; lat = 0; bcnt = 0; bh = 0; bv = 0; bh_idx = -1; bv_idx = -1;
      vsync = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
         if (bounce_h && !bh) begin bh = 1; bh_idx = int'(bounce_idx); end
         if (bounce_v && !bv) begin bv = 1; bv_idx = int'(bounce_idx); end
         if (frame_done) seen = 1;
      end
      if (!seen) chk("frame_timeout", 0, 1);
      tick();
      vsync = 1'b0;
      tick();
   endtask

   task automatic cfg_write(input int i, input int h, input int v, input int hm, input int vm,
                            output int wait_cnt);
      bit got;
      got = 0; wait_cnt = 0;
      cfg_idx = IW'(i); cfg_hpos = 9'(h); cfg_vpos = 9'(v);
      cfg_hmove = 9'(hm); cfg_vmove = 9'(vm);
      cfg_we = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         wait_cnt++;
         if (cfg_ack) got = 1;
      end
      if (!got) chk("cfg_ack_timeout", 0, 1);
      @(posedge clk); #2;
      cfg_we = 1'b0;
      tick();
   endtask

   task automatic wait_done(input int budget, output int ndone);
      ndone = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (frame_done) ndone++;
      end
   endtask

   int lat, bcnt, bh_idx, bv_idx, wc, nd;
   bit bh, bv;

   initial begin
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      for (int i = 0; i < N; i++) read_ball(i, 128, 128);
      chk("reset_busy", int'(busy), 0);
      chk("reset_overrun", int'(overrun), 0);
      chk("reset_cfg_ack", int'(cfg_ack), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_bounce_idx", int'(bounce_idx), 0);
      tick();

      // First frame: latency and busy length
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      chk("frame_latency", lat, 7);
      chk("busy_cycles", bcnt, 5);
      read_ball(0, 126, 130);
      read_ball(3, 126, 130);
      tick();

      // Horizontal bounce at right edge
      cfg_write(1, 250, 128, 2, 2, wc);
      chk("idle_ack_wait", wc, 1);
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      chk("bounce_h_seen", int'(bh), 1);
      chk("bounce_h_idx", bh_idx, 1);
      chk("bounce_v_quiet", int'(bv), 0);
      read_ball(1, 250, 130);
      chk("model_hmove1", m_hm[1], 9'h1FE);
      tick();
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      read_ball(1, 248, 132);
      tick();

      // Vertical bounce from negative wrap
      cfg_write(2, 100, 1, 0, 9'h1FE, wc);
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      chk("bounce_v_seen", int'(bv), 1);
      chk("bounce_v_idx", bv_idx, 2);
      read_ball(2, 100, 1);
      chk("model_vmove2", m_vm[2], 2);
      tick();
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      read_ball(2, 100, 3);
      tick();

      // Config write stalls while a frame is in flight
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      cfg_write(3, 10, 20, 1, 1, wc);
      chk("busy_ack_wait", wc, 7);
      read_ball(3, 10, 20);
      tick();

      // Edge and write in the same idle cycle: write accepted, frame follows
      cfg_idx = 2'd0; cfg_hpos = 9'd50; cfg_vpos = 9'd60; cfg_hmove = 9'd1; cfg_vmove = 9'd1;
      cfg_we = 1'b1; vsync = 1'b1;
      @(negedge clk);
      chk("same_cycle_ack", int'(cfg_ack), 1);
      @(posedge clk); #2;
      cfg_we = 1'b0;
      wait_done(12, nd);
      chk("same_cycle_frames", nd, 1);
      tick();
      vsync = 1'b0;
      tick();
      read_ball(0, 51, 61);
      tick();

      // Closely spaced vsync rises: overrun latches, back-to-back passes
      vsync = 1'b1; tick(); vsync = 1'b0; tick();
      vsync = 1'b1; tick(); vsync = 1'b0; tick();
      vsync = 1'b1; tick(); vsync = 1'b0;
      wait_done(20, nd);
      chk("overrun_frames", nd, 2);
      chk("overrun_sticky", int'(overrun), 1);
      tick();

      // Reset in the middle of an update pass
      vsync = 1'b1; tick(); vsync = 1'b0; tick(); tick();
      chk("mid_frame_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("reset_async_busy", int'(busy), 0);
      chk("reset_async_overrun", int'(overrun), 0);
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < N; i++) read_ball(i, 128, 128);
      tick();
      frame(lat, bcnt, bh, bh_idx, bv, bv_idx);
      chk("post_reset_latency", lat, 7);
      read_ball(0, 126, 130);
      read_ball(2, 126, 130);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
